rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- Round-robin arbiter that shares one single-owner resource (e.g. a bus or FSM-driven datapath) between NUM_REQ requesters.
- Grant is held while the owner keeps its request, subject to a MAX_HOLD fairness timeout.
- Grants are registered.
- One mandatory dead cycle separates consecutive grants so owners never overlap.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum grant cycles before forced handoff when others are waiting; 0 disables the timeout.
- IDX_W, $clog2(NUM_REQ), width of grant_idx (derived, not overridden).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request vector, level-sensitive; bit i belongs to requester i.
- grant  output  NUM_REQ  registered one-hot grant, all-zero when no owner.
- grant_valid  output  1  high iff grant is non-zero.
- grant_idx  output  IDX_W  index of current owner; holds last owner when grant_valid=0.
- preempt  output  1  one-cycle pulse on the cycle grant drops because of timeout.

Behaviour:
- Reset (reset low, asynchronous): grant=0, grant_valid=0, grant_idx=0, preempt=0, state=IDLE, hold_cnt=0, last_ptr=NUM_REQ-1 (so requester 0 has top priority first).
- States: IDLE, GRANT, GAP.
- Round-robin pick: first set bit of req searching last_ptr+1, last_ptr+2, ... modulo NUM_REQ. On wrap-around, index NUM_REQ-1 is followed by 0.
- IDLE: if req!=0, pick winner w. Next cycle: grant=1<<w, grant_idx=w, last_ptr=w, hold_cnt=1, state=GRANT. If req==0, stay in IDLE.
- Latency: request to grant is 1 cycle from IDLE and 2 cycles after a release (GAP cycle).
- GRANT, release: if req[grant_idx]==0, the next cycle has grant=0, state=GAP, no preempt.
- GRANT, timeout: else if MAX_HOLD!=0, hold_cnt==MAX_HOLD and (req with owner bit masked)!=0, the next cycle has grant=0, preempt=1 for that one cycle, state=GAP.
- GRANT, otherwise: stay in GRANT. hold_cnt increments and saturates at MAX_HOLD. A lone owner keeps the grant indefinitely.
- GAP: grant=0. If req!=0, pick the winner from the current req using last_ptr (the previous owner gets lowest priority but may win again if alone). Next cycle: GRANT with hold_cnt=1. If req==0, go to IDLE.
- Simultaneous release and timeout: release takes precedence, so preempt stays 0.
- A request dropped before being granted is simply not picked; requesters are not latched.
- Changes to other req bits during GRANT do not affect the grant.
- Reset asserted mid-grant: grant clears asynchronously and last_ptr returns to NUM_REQ-1.
- Invariants: grant is always one-hot or zero; grant_valid==|grant; preempt never overlaps grant!=0.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1 bit.

Decomposition:
- Package rr_arb_pkg holds the state enum (IDLE, GRANT, GAP) and the clog2-based width helper constants.
- One combinational sub-module, rr_priority_pick (inputs req, last_ptr; outputs found, winner_idx), implements the rotate-and-find-first search.
- The FSM, hold counter and output registers stay in rr_lock_arbiter.

Test Plan:
- Reset and first grant: hold reset low, req=4'b1010, release reset, then req stays 4'b1010 → grant=4'b0010, grant_idx=1 one cycle after reset release; first grant goes to 1, not 3.
- Round-robin rotation: req=4'b1111 held, each owner drops its bit for one cycle after 2 grant cycles → grant order 0,1,2,3,0 with exactly one grant=0 GAP cycle between owners.
- Timeout preempt: MAX_HOLD=8, req=4'b0001 held, req[2] set at grant cycle 3 → grant[0] for 8 cycles, then grant=0 with preempt=1, then grant=4'b0100.
- Lone owner no preempt: MAX_HOLD=8, only req[3] high for 30 cycles → grant=4'b1000 continuous, preempt never set.
- Wrap-around: last owner 3, in GAP req=4'b1001 → winner 0; last owner 0, req=4'b0001 only → owner 0 re-granted after one GAP cycle.
- Async reset mid-grant: grant=4'b0100 and reset pulses low between clock edges → grant=0 immediately, and after release req=4'b0100 gives grant_idx=2 via IDLE in 1 cycle.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants for the round-robin lock arbiter: FSM state encodings and
// width helpers used to size the owner index and the hold counter.
package rr_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_GRANT = 2'd1;
   localparam state_t ST_GAP   = 2'd2;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Counter must hold MAX_HOLD itself; a disabled timeout still needs one bit.
   function automatic int cnt_width(input int max_hold);
      return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating find-first: returns the first set req bit after last_ptr,
// wrapping from NUM_REQ-1 back to 0, so last_ptr itself is searched last.
module rr_priority_pick
   import rr_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_ptr,
   output logic               found,
   output logic [IDX_W-1:0]   winner_idx
);

   logic [IDX_W-1:0] w_cand;

   // Walk the candidates farthest-first so the nearest set bit is written last.
   always_comb begin
      int pos;
      found      = 1'b0;
      winner_idx = {IDX_W{1'b0}};
      w_cand     = {IDX_W{1'b0}};
      pos        = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         pos = int'(last_ptr) + k;
         if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
         end else begin
            pos = pos;
         end
         w_cand = IDX_W'(pos);
         if (req[w_cand]) begin
            found      = 1'b1;
            winner_idx = w_cand;
         end else begin
            found      = found;
            winner_idx = winner_idx;
         end
      end
   end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter for a single-owner resource: the owner keeps the grant
// while requesting, bounded by MAX_HOLD when others wait, with one dead cycle between owners.
module rr_lock_arbiter
   import rr_arb_pkg::*;
#(
   parameter  int NUM_REQ  = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IDX_W    = idx_width(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               preempt
);

   localparam int                 CNT_W    = cnt_width(MAX_HOLD);
   localparam logic [CNT_W-1:0]   MAX_C    = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0]   PTR_INIT = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_hold_cnt;
   logic [IDX_W-1:0]   r_last_ptr;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_grant_valid;
   logic [IDX_W-1:0]   r_grant_idx;
   logic               r_preempt;

   state_t             w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [NUM_REQ-1:0] w_grant_nxt;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic               w_preempt_nxt;
   logic               w_found;
   logic [IDX_W-1:0]   w_winner;
   logic [NUM_REQ-1:0] w_others;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (req),
      .last_ptr   (r_last_ptr),
      .found      (w_found),
      .winner_idx (w_winner)
   );

   assign w_others = req & ~r_grant;

   // Next-state, hold counter and next output values for the three-state FSM.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_hold_cnt;
      w_ptr_nxt     = r_last_ptr;
      w_grant_nxt   = r_grant;
      w_idx_nxt     = r_grant_idx;
      w_preempt_nxt = 1'b0;
      case (r_state)
         ST_IDLE, ST_GAP: begin
            if (w_found) begin
               w_state_nxt = ST_GRANT;
               w_grant_nxt = ONE_HOT0 << w_winner;
               w_idx_nxt   = w_winner;
               w_ptr_nxt   = w_winner;
               w_cnt_nxt   = CNT_ONE;
            end else begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = {NUM_REQ{1'b0}};
            end
         end
         ST_GRANT: begin
            // Release wins over timeout, so a simultaneous drop never pulses preempt.
            if (!req[r_grant_idx]) begin
               w_state_nxt = ST_GAP;
               w_grant_nxt = {NUM_REQ{1'b0}};
            end else if ((MAX_HOLD != 0) && (r_hold_cnt == MAX_C) && (|w_others)) begin
               w_state_nxt   = ST_GAP;
               w_grant_nxt   = {NUM_REQ{1'b0}};
               w_preempt_nxt = 1'b1;
            end else if (r_hold_cnt < MAX_C) begin
               w_cnt_nxt = r_hold_cnt + CNT_ONE;
            end else begin
               w_cnt_nxt = r_hold_cnt;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = {NUM_REQ{1'b0}};
         end
      endcase
   end

   // State and registered outputs; reset leaves requester 0 first in line.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_hold_cnt    <= {CNT_W{1'b0}};
         r_last_ptr    <= PTR_INIT;
         r_grant       <= {NUM_REQ{1'b0}};
         r_grant_valid <= 1'b0;
         r_grant_idx   <= {IDX_W{1'b0}};
         r_preempt     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_hold_cnt    <= w_cnt_nxt;
         r_last_ptr    <= w_ptr_nxt;
         r_grant       <= w_grant_nxt;
         r_grant_valid <= |w_grant_nxt;
         r_grant_idx   <= w_idx_nxt;
         r_preempt     <= w_preempt_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_valid = r_grant_valid;
   assign grant_idx   = r_grant_idx;
   assign preempt     = r_preempt;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (NUM_REQ=4, MAX_HOLD=8): each step queues the
// hand-derived expected outputs for the next clock edge and checks them after it.
module tb_rr_lock_arbiter;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] i;
      logic       p;
   } exp_t;

   logic       clock;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_idx;
   logic       preempt;

   int   n_tests;
   int   n_fail;
   exp_t sb_q[$];

   rr_lock_arbiter #(
      .NUM_REQ  (4),
      .MAX_HOLD (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .preempt     (preempt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input exp_t e);
      chk({tag, ".grant"}, {4'd0, grant}, {4'd0, e.g});
      chk({tag, ".valid"}, {7'd0, grant_valid}, {7'd0, |e.g});
      chk({tag, ".idx"}, {6'd0, grant_idx}, {6'd0, e.i});
      chk({tag, ".preempt"}, {7'd0, preempt}, {7'd0, e.p});
   endtask

   // Drive req on the falling edge, queue what the next rising edge must produce.
   task automatic step(input string tag, input logic [3:0] r, input logic [3:0] eg,
                       input logic [1:0] ei, input logic ep);
      exp_t e;
      @(negedge clock);
      req = r;
      sb_q.push_back('{g: eg, i: ei, p: ep});
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb_q.pop_front();
         chk_out(tag, e);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      req     = 4'b1010;
      repeat (3) @(posedge clock);
      #1;
      chk_out("reset", '{g: 4'b0000, i: 2'd0, p: 1'b0});
      @(negedge clock);
      reset = 1'b1;

      // First grant goes to requester 1 (searching from 0), then rotation.
      step("first",  4'b1010, 4'b0010, 2'd1, 1'b0);
      step("rot1a",  4'b1111, 4'b0010, 2'd1, 1'b0);
      step("rot1g",  4'b1101, 4'b0000, 2'd1, 1'b0);
      step("rot2a",  4'b1111, 4'b0100, 2'd2, 1'b0);
      step("rot2b",  4'b1111, 4'b0100, 2'd2, 1'b0);
      step("rot2g",  4'b1011, 4'b0000, 2'd2, 1'b0);
      step("rot3a",  4'b1111, 4'b1000, 2'd3, 1'b0);
      step("rot3b",  4'b1111, 4'b1000, 2'd3, 1'b0);
      step("rot3g",  4'b0111, 4'b0000, 2'd3, 1'b0);
      step("wrap0",  4'b1001, 4'b0001, 2'd0, 1'b0);
      step("own0b",  4'b0001, 4'b0001, 2'd0, 1'b0);
      step("own0g",  4'b0000, 4'b0000, 2'd0, 1'b0);
      step("regrant0", 4'b0001, 4'b0001, 2'd0, 1'b0);

      // Owner 0 has one grant cycle; req[2] joins, forced handoff after 8 cycles.
      step("to_c2",  4'b0001, 4'b0001, 2'd0, 1'b0);
      for (int k = 3; k <= 8; k++) begin
         step($sformatf("to_c%0d", k), 4'b0101, 4'b0001, 2'd0, 1'b0);
      end
      step("to_pre", 4'b0101, 4'b0000, 2'd0, 1'b1);
      step("to_new", 4'b0101, 4'b0100, 2'd2, 1'b0);

      // Owner 2 reaches MAX_HOLD and releases in the same cycle: no preempt.
      for (int k = 2; k <= 8; k++) begin
         step($sformatf("sim_c%0d", k), 4'b0101, 4'b0100, 2'd2, 1'b0);
      end
      step("sim_rel", 4'b0001, 4'b0000, 2'd2, 1'b0);
      step("to_idle", 4'b0000, 4'b0000, 2'd2, 1'b0);
      step("idle",    4'b0000, 4'b0000, 2'd2, 1'b0);

      // Lone owner keeps the grant well past MAX_HOLD.
      step("lone_st", 4'b1000, 4'b1000, 2'd3, 1'b0);
      for (int k = 0; k < 30; k++) begin
         step($sformatf("lone_%0d", k), 4'b1000, 4'b1000, 2'd3, 1'b0);
      end

      step("pre_rst_g", 4'b0100, 4'b0000, 2'd3, 1'b0);
      step("pre_rst",   4'b0100, 4'b0100, 2'd2, 1'b0);

      // Asynchronous reset between edges clears outputs immediately.
      #2;
      reset = 1'b0;
      #1;
      chk_out("async_rst", '{g: 4'b0000, i: 2'd0, p: 1'b0});
      @(negedge clock);
      req   = 4'b0000;
      reset = 1'b1;
      // last_ptr back at 3 makes requester 2 win over 3 straight from IDLE.
      step("post_rst", 4'b1100, 4'b0100, 2'd2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
